// File: rtl/cpu_bus_initiator_pkg.sv
// cpu_bus_initiator_pkg: shared states, default timing and counter sizing
package cpu_bus_initiator_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;
  localparam int DEF_SETUP = 1;
  localparam int DEF_STROBE = 2;
  localparam int DEF_HOLD = 1;
  function automatic int cnt_width(input int s, input int st, input int h);
    int m;
    m = s > st ? s : st;
    m = m > h ? m : h;
    return $clog2(m + 1);
  endfunction
  localparam int CNT_W = cnt_width(DEF_SETUP, DEF_STROBE, DEF_HOLD);
endpackage

// File: rtl/bus_phase_timer.sv
// bus_phase_timer: loadable down-counter flagging the last cycle of a phase
module bus_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] count;
  // load on phase entry, then count down to zero and rest there
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  assign done = count == '0;
endmodule

// File: rtl/cpu_bus_initiator.sv
// cpu_bus_initiator: turns valid/ready commands into fixed-phase CPU bus cycles
module cpu_bus_initiator
  import cpu_bus_initiator_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP,
  parameter int STROBE_CYCLES = DEF_STROBE,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic        clk_12_5875,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_address,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_fpga,
  output logic [15:0] cpu_address,
  output logic [7:0]  data_in,
  output logic        data_oe,
  output logic        write_enable_B,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_data_enable,
  output logic        busy
);
  localparam int W = cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
    $error("cpu_bus_initiator: every phase must last at least one cycle");
  end
  state_t state, next;
  logic op_write, accept, load, done, next_write;
  logic [W-1:0] load_value;
  assign accept = cmd_valid && cmd_ready;
  assign next_write = accept ? cmd_write : op_write;
  bus_phase_timer #(.W(W)) timer (
    .clk(clk_12_5875),
    .rst(rst),
    .load(load),
    .value(load_value),
    .done(done)
  );
  // phase sequencing; the timer is reloaded with the new phase length on every entry
  always_comb begin
    next = state;
    load = 1'b0;
    load_value = '0;
    case (state)
      IDLE: if (accept) begin
        next = SETUP;
        load = 1'b1;
        load_value = W'(SETUP_CYCLES - 1);
      end
      SETUP: if (done) begin
        next = STROBE;
        load = 1'b1;
        load_value = W'(STROBE_CYCLES - 1);
      end
      STROBE: if (done) begin
        next = HOLD;
        load = 1'b1;
        load_value = W'(HOLD_CYCLES - 1);
      end
      HOLD: next = done ? RESP : HOLD;
      RESP: next = rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  // state, command latch and read capture on the final strobe cycle
  always_ff @(posedge clk_12_5875 or posedge rst)
    if (rst) begin
      state <= IDLE;
      op_write <= 1'b0;
      cpu_address <= '0;
      data_in <= '0;
      rsp_rdata <= '0;
      rsp_fpga <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        op_write <= cmd_write;
        cpu_address <= cmd_address;
        data_in <= cmd_wdata;
        rsp_rdata <= '0;
        rsp_fpga <= 1'b0;
      end
      if (state == STROBE && done && !op_write) begin
        rsp_rdata <= bus_rdata;
        rsp_fpga <= bus_data_enable;
      end
    end
  // bus and handshake outputs registered from the upcoming state
  always_ff @(posedge clk_12_5875 or posedge rst)
    if (rst) begin
      data_oe <= 1'b0;
      write_enable_B <= 1'b1;
      rsp_valid <= 1'b0;
      busy <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      data_oe <= next_write && (next == SETUP || next == STROBE || next == HOLD);
      write_enable_B <= !(next_write && next == STROBE);
      rsp_valid <= next == RESP;
      busy <= next != IDLE;
      cmd_ready <= next == IDLE;
    end
endmodule

// File: tb/tb_cpu_bus_initiator.sv
// tb_cpu_bus_initiator: randomized and directed checks against a phase-window model
module tb_cpu_bus_initiator;
  logic clk = 1'b0;
  logic rst, sel, cmd_valid, cmd_write, rsp_ready, bus_data_enable;
  logic [15:0] cmd_address;
  logic [7:0] cmd_wdata, bus_rdata;
  logic [1:0] rdy, rv, fpga, oe, web, bsy;
  logic [15:0] addr [2];
  logic [7:0] din [2];
  logic [7:0] rdata [2];
  logic nxt_w;
  logic [15:0] nxt_a;
  logic [7:0] nxt_d;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cpu_bus_initiator dut0 (
    .clk_12_5875(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy[0]),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rdata[0]), .rsp_fpga(fpga[0]),
    .cpu_address(addr[0]), .data_in(din[0]), .data_oe(oe[0]), .write_enable_B(web[0]),
    .bus_rdata(bus_rdata), .bus_data_enable(bus_data_enable), .busy(bsy[0])
  );

  cpu_bus_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clk_12_5875(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(rdy[1]),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready && sel), .rsp_rdata(rdata[1]), .rsp_fpga(fpga[1]),
    .cpu_address(addr[1]), .data_in(din[1]), .data_oe(oe[1]), .write_enable_B(web[1]),
    .bus_rdata(bus_rdata), .bus_data_enable(bus_data_enable), .busy(bsy[1])
  );

  // one transaction; cycle k is the k-th cycle after the accepting edge
  task automatic run_op(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input logic den, input int d, input bit offer_next);
    int s, st, h, l;
    logic [28:0] obs, exp_v;
    logic [8:0] obs_r, exp_r;
    s = sel ? 2 : 1;
    st = sel ? 3 : 2;
    h = sel ? 2 : 1;
    l = s + st + h + 1;
    total++;
    if (rdy[sel] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept got=%b want=1", rdy[sel]);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_address = a;
    cmd_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_address = 16'($urandom);
    cmd_wdata = 8'($urandom);
    cmd_write = 1'($urandom);
    for (int k = 1; k <= l + d; k++) begin
      bus_rdata = (k == s + st) ? rd : 8'($urandom);
      bus_data_enable = (k == s + st) ? den : 1'($urandom);
      rsp_ready = (k == l + d);
      if (offer_next && k >= l) begin
        cmd_valid = 1'b1;
        cmd_write = nxt_w;
        cmd_address = nxt_a;
        cmd_wdata = nxt_d;
      end
      obs = {addr[sel], din[sel], web[sel], oe[sel], rv[sel], rdy[sel], bsy[sel]};
      exp_v = {a, wd, !(wr && k > s && k <= s + st), wr && k < l, k >= l, 1'b0, 1'b1};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bus_cycle k=%0d sel=%0d got addr/din/weB/oe/rv/rdy/busy=%h want=%h",
                 k, sel, obs, exp_v);
      end
      if (k == l) begin
        obs_r = {rdata[sel], fpga[sel]};
        exp_r = wr ? 9'h0 : {rd, den};
        total++;
        if (obs_r !== exp_r) begin
          bad++;
          $display("FAIL response_data got rdata/fpga=%h want=%h", obs_r, exp_r);
        end
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    obs = {addr[sel], din[sel], web[sel], oe[sel], rv[sel], rdy[sel], bsy[sel]};
    exp_v = {a, wd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL back_to_idle got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    sel = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    bus_rdata = '0;
    bus_data_enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {addr[0], din[0], rdata[0], fpga[0], web[0], oe[0], rv[0], bsy[0]};
    total++;
    if (obs !== {16'h0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got=%h", obs);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rdy[0] !== 1'b1 || rv[0] !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_reset got rdy=%b rv=%b want rdy=1 rv=0", rdy[0], rv[0]);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_address = 16'hBEEF;
    cmd_wdata = 8'h5A;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (web[0] !== 1'b0 || oe[0] !== 1'b1) begin
      bad++;
      $display("FAIL strobe_before_reset got weB=%b oe=%b want weB=0 oe=1", web[0], oe[0]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (web[0] !== 1'b1 || oe[0] !== 1'b0 || bsy[0] !== 1'b0 || addr[0] !== 16'h0) begin
      bad++;
      $display("FAIL async_reset_mid_strobe got weB=%b oe=%b busy=%b addr=%h want 1/0/0/0000",
               web[0], oe[0], bsy[0], addr[0]);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rdy[0] !== 1'b1 || rv[0] !== 1'b0 || web[0] !== 1'b1) begin
      bad++;
      $display("FAIL after_mid_reset got rdy=%b rv=%b weB=%b want 1/0/1", rdy[0], rv[0], web[0]);
    end
  endtask

  task automatic test_write_default();
    sel = 1'b0;
    run_op(1'b1, 16'h4000, 8'hA5, 8'hFF, 1'b1, 0, 1'b0);
  endtask

  task automatic test_read_fpga();
    sel = 1'b0;
    run_op(1'b0, 16'h7000, 8'h00, 8'h3C, 1'b1, 1, 1'b0);
  endtask

  task automatic test_read_external();
    sel = 1'b0;
    run_op(1'b0, 16'h8123, 8'h00, 8'h11, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_op(1'b1, 16'h2001, 8'h01, 8'h00, 1'b0, 0, 1'b0);
    run_op(1'b0, 16'h2002, 8'h00, 8'h77, 1'b1, 0, 1'b0);
    run_op(1'b1, 16'h2003, 8'h03, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    nxt_w = 1'b1;
    nxt_a = 16'h5555;
    nxt_d = 8'hC3;
    run_op(1'b0, 16'h3000, 8'h00, 8'h42, 1'b1, 5, 1'b1);
    run_op(nxt_w, nxt_a, nxt_d, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic test_params();
    sel = 1'b1;
    run_op(1'b1, 16'h6000, 8'h99, 8'h00, 1'b0, 0, 1'b0);
    run_op(1'b0, 16'h6001, 8'h00, 8'hE7, 1'b1, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 24; i++)
      run_op(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_default();
    test_read_fpga();
    test_read_external();
    test_back_to_back();
    test_backpressure();
    test_params();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
